// File: rtl/cpi_pkg.sv
// Shared definitions for the cpi_muldiv coprocessor: opcode field, subop codes, FSM states.
// `CPI_MULDIV_SIGNED_EN enables the signed subops MULH/DIV/REM.
package cpi_pkg;

    localparam int OP_W = 4;
    localparam logic [OP_W-1:0] OPCODE_DEF = 4'h6;

    localparam logic [3:0] SUBOP_MUL   = 4'd0;
    localparam logic [3:0] SUBOP_MULHU = 4'd1;
    localparam logic [3:0] SUBOP_DIVU  = 4'd2;
    localparam logic [3:0] SUBOP_REMU  = 4'd3;
    localparam logic [3:0] SUBOP_MULH  = 4'd4;
    localparam logic [3:0] SUBOP_DIV   = 4'd5;
    localparam logic [3:0] SUBOP_REM   = 4'd6;

`ifdef CPI_MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic subop_signed(input logic [3:0] s);
        return SIGNED_EN && ((s == SUBOP_MULH) || (s == SUBOP_DIV) || (s == SUBOP_REM));
    endfunction

    function automatic logic subop_known(input logic [3:0] s);
        return (s <= SUBOP_REMU) || subop_signed(s);
    endfunction

    function automatic logic subop_is_div(input logic [3:0] s);
        return (s == SUBOP_DIVU) || (s == SUBOP_REMU) || (s == SUBOP_DIV) || (s == SUBOP_REM);
    endfunction

endpackage

// File: rtl/cpi_muldiv_if.sv
// Coprocessor interface bundle between the core (master) and a coprocessor (slave).
interface cpi_muldiv_if;
    logic        cpi_valid;
    logic [31:0] cpi_inst;
    logic [31:0] cpi_r1;
    logic [31:0] cpi_r2;
    logic        cpi_ready;
    logic        cpi_wait;
    logic [31:0] cpi_data;
    logic        cpi_drop;

    modport master (
        output cpi_valid, cpi_inst, cpi_r1, cpi_r2,
        input  cpi_ready, cpi_wait, cpi_data, cpi_drop
    );

    modport slave (
        input  cpi_valid, cpi_inst, cpi_r1, cpi_r2,
        output cpi_ready, cpi_wait, cpi_data, cpi_drop
    );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Purely combinational; acc holds {hi/remainder, lo/multiplier-or-quotient}.
module muldiv_step (
    input  logic [64:0] acc_i,
    input  logic [31:0] opnd_i,
    input  logic        div_i,
    output logic [64:0] acc_o
);
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [33:0] rem_diff;
    logic        unused_top;

    // Bit 64 never carries information between steps: mul sums land in [63:31],
    // and a divide remainder is always below the divisor.
    assign unused_top = acc_i[64];

    assign mul_sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
    assign rem_sh   = {acc_i[63:32], acc_i[31]};
    assign rem_diff = {1'b0, rem_sh} - {2'b00, opnd_i};

    always_comb begin
        acc_o = {1'b0, mul_sum, acc_i[31:1]};
        if (div_i) begin
            if (rem_diff[33]) begin
                acc_o = {rem_sh, acc_i[30:0], 1'b0};
            end else begin
                acc_o = {rem_diff[32:0], acc_i[30:0], 1'b1};
            end
        end
    end
endmodule

// File: rtl/cpi_muldiv.sv
// Iterative 32-bit multiply/divide coprocessor; fixed 33-cycle latency from claim to cpi_ready.
// `CPI_MULDIV_SIGNED_EN adds signed MULH/DIV/REM (magnitude datapath, sign fixed on output).
module cpi_muldiv
    import cpi_pkg::*;
#(
    parameter logic [OP_W-1:0] OPCODE = OPCODE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    cpi_muldiv_if.slave cpi
);
    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [64:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [3:0]  subop_q, subop_d;
    logic        ok_q, ok_d;
    logic        neg_q, neg_d;

    logic        claim;
    logic [3:0]  sub_in;
    logic        sgn_in, div_in, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [64:0] step_acc;
    logic [63:0] prod_signed;
    logic [31:0] result;
    logic        unused_inst;

    assign sub_in      = cpi.cpi_inst[27:24];
    assign claim       = cpi.cpi_valid && (cpi.cpi_inst[31:28] == OPCODE);
    assign unused_inst = ^cpi.cpi_inst[23:0];

    assign sgn_in = subop_signed(sub_in);
    assign div_in = subop_is_div(sub_in);
    assign a_neg  = sgn_in && cpi.cpi_r1[31];
    assign b_neg  = sgn_in && cpi.cpi_r2[31];
    assign a_mag  = a_neg ? (32'd0 - cpi.cpi_r1) : cpi.cpi_r1;
    assign b_mag  = b_neg ? (32'd0 - cpi.cpi_r2) : cpi.cpi_r2;

    muldiv_step u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (subop_is_div(subop_q)),
        .acc_o  (step_acc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 65'd0;
            opnd_q  <= 32'd0;
            subop_q <= 4'd0;
            ok_q    <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            subop_q <= subop_d;
            ok_q    <= ok_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        subop_d = subop_q;
        ok_d    = ok_q;
        neg_d   = neg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (claim) begin
                    subop_d = sub_in;
                    ok_d    = subop_known(sub_in);
                    cnt_d   = 5'd31;
                    opnd_d  = div_in ? b_mag : a_mag;
                    acc_d   = {33'd0, div_in ? a_mag : b_mag};
                    // Signed x/0 must come out as -1, so the quotient is never negated then.
                    unique case (sub_in)
                        SUBOP_REM: neg_d = a_neg;
                        SUBOP_DIV: neg_d = (a_neg ^ b_neg) && (cpi.cpi_r2 != 32'd0);
                        default:   neg_d = a_neg ^ b_neg;
                    endcase
                    state_d = subop_known(sub_in) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                acc_d = step_acc;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign prod_signed = neg_q ? (64'd0 - acc_q[63:0]) : acc_q[63:0];

    always_comb begin
        result = 32'd0;
        unique case (subop_q)
            SUBOP_MUL:   result = acc_q[31:0];
            SUBOP_MULHU: result = acc_q[63:32];
            SUBOP_DIVU:  result = acc_q[31:0];
            SUBOP_REMU:  result = acc_q[63:32];
            SUBOP_MULH:  result = prod_signed[63:32];
            SUBOP_DIV:   result = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
            SUBOP_REM:   result = neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            default:     result = 32'd0;
        endcase
    end

    assign cpi.cpi_ready = (state_q == ST_DONE);
    assign cpi.cpi_drop  = (state_q == ST_DONE) && ok_q;
    assign cpi.cpi_data  = ((state_q == ST_DONE) && ok_q) ? result : 32'd0;
    assign cpi.cpi_wait  = claim && (state_q != ST_DONE);
endmodule

// File: tb/tb_cpi_muldiv.sv
// Self-checking bench for cpi_muldiv: scoreboard of expected result/drop/latency per issued op.
// Signed cases are selected by `CPI_MULDIV_SIGNED_EN, matching the DUT build.
module tb_cpi_muldiv;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        drop;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    cpi_muldiv_if cpi ();

    cpi_muldiv #(.OPCODE(4'h6)) dut (
        .clk (clk),
        .rst (rst),
        .cpi (cpi)
    );

    always #5 clk = ~clk;

    // Issue one claimed op, hold valid until cpi_ready, then compare against the queue head.
    task automatic run_op(input string name, input logic [3:0] sub, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ed, input logic edrop,
                          input int elat);
        exp_t e;
        int   cyc;
        logic got;
        logic wait_ok;
        e.name = name; e.data = ed; e.drop = edrop; e.lat = elat;
        exp_q.push_back(e);
        @(negedge clk);
        cpi.cpi_valid = 1'b1;
        cpi.cpi_inst  = {4'h6, sub, 24'h5A5A5A};
        cpi.cpi_r1    = a;
        cpi.cpi_r2    = b;
        cyc = 0; got = 1'b0; wait_ok = 1'b1;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                cpi.cpi_r1 = $urandom;
                cpi.cpi_r2 = $urandom;
            end
            if (cpi.cpi_ready === 1'b1) got = 1'b1;
            else if (cpi.cpi_wait !== 1'b1) wait_ok = 1'b0;
        end
        e = exp_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s timeout: no cpi_ready within %0d cycles", e.name, cyc);
        end else begin
            checks++;
            if (cpi.cpi_data !== e.data) begin
                failures++;
                $display("FAIL %s data: got %h expected %h", e.name, cpi.cpi_data, e.data);
            end
            checks++;
            if (cpi.cpi_drop !== e.drop) begin
                failures++;
                $display("FAIL %s drop: got %b expected %b", e.name, cpi.cpi_drop, e.drop);
            end
            if (cyc != e.lat) begin
                failures++;
                $display("FAIL %s latency: got %0d expected %0d", e.name, cyc, e.lat);
            end
            checks++;
            if (cpi.cpi_wait !== 1'b0) begin
                failures++;
                $display("FAIL %s wait_in_done: got %b expected 0", e.name, cpi.cpi_wait);
            end
        end
        checks++;
        if (!wait_ok) begin
            failures++;
            $display("FAIL %s wait_while_busy: got dropout expected 1", e.name);
        end
        cpi.cpi_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (cpi.cpi_ready !== 1'b0) begin
            failures++; $display("FAIL reset ready: got %b expected 0", cpi.cpi_ready);
        end
        checks++;
        if (cpi.cpi_drop !== 1'b0) begin
            failures++; $display("FAIL reset drop: got %b expected 0", cpi.cpi_drop);
        end
        checks++;
        if (cpi.cpi_data !== 32'd0) begin
            failures++; $display("FAIL reset data: got %h expected 0", cpi.cpi_data);
        end
        checks++;
        if (cpi.cpi_wait !== 1'b0) begin
            failures++; $display("FAIL reset wait: got %b expected 0", cpi.cpi_wait);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unsigned;
        run_op("mul_7x6",    4'd0, 32'd7, 32'd6, 32'd42, 1'b1, 33);
        run_op("mulhu_max",  4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 33);
        run_op("divu_100_7", 4'd2, 32'd100, 32'd7, 32'd14, 1'b1, 33);
        run_op("remu_100_7", 4'd3, 32'd100, 32'd7, 32'd2, 1'b1, 33);
        run_op("divu_5_0",   4'd2, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 33);
        run_op("remu_5_0",   4'd3, 32'd5, 32'd0, 32'd5, 1'b1, 33);
    endtask

    task automatic test_random;
        logic [31:0] a, b, ex;
        logic [63:0] p;
        logic [3:0]  s;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
            s = 4'($urandom_range(0, 3));
            p = {32'd0, a} * {32'd0, b};
            case (s)
                4'd0:    ex = p[31:0];
                4'd1:    ex = p[63:32];
                4'd2:    ex = (b == 0) ? 32'hFFFF_FFFF : a / b;
                default: ex = (b == 0) ? a : a % b;
            endcase
            run_op("random", s, a, b, ex, 1'b1, 33);
        end
    endtask

    task automatic test_foreign_op;
        logic seen;
        logic wait_seen;
        seen = 1'b0; wait_seen = 1'b0;
        @(negedge clk);
        cpi.cpi_valid = 1'b1;
        cpi.cpi_inst  = {4'h7, 4'h0, 24'h0};
        cpi.cpi_r1    = 32'd3;
        cpi.cpi_r2    = 32'd4;
        repeat (40) begin
            @(negedge clk);
            if (cpi.cpi_ready !== 1'b0) seen = 1'b1;
            if (cpi.cpi_wait !== 1'b0) wait_seen = 1'b1;
        end
        cpi.cpi_valid = 1'b0;
        checks++;
        if (seen) begin
            failures++; $display("FAIL foreign_op ready: got 1 expected 0");
        end
        checks++;
        if (wait_seen) begin
            failures++; $display("FAIL foreign_op wait: got 1 expected 0");
        end
    endtask

    task automatic test_bad_subop;
        run_op("subop_F", 4'hF, 32'd9, 32'd9, 32'd0, 1'b0, 1);
`ifndef CPI_MULDIV_SIGNED_EN
        run_op("mulh_disabled", 4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        run_op("div_disabled",  4'd5, 32'd10, 32'd2, 32'd0, 1'b0, 1);
        run_op("rem_disabled",  4'd6, 32'd10, 32'd3, 32'd0, 1'b0, 1);
`endif
    endtask

    task automatic test_reset_mid_busy;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        cpi.cpi_valid = 1'b1;
        cpi.cpi_inst  = {4'h6, 4'h0, 24'h0};
        cpi.cpi_r1    = 32'd123;
        cpi.cpi_r2    = 32'd456;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        cpi.cpi_valid = 1'b0;
        #1;
        checks++;
        if (cpi.cpi_ready !== 1'b0 || cpi.cpi_drop !== 1'b0 || cpi.cpi_data !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_busy outputs: got ready=%b drop=%b data=%h expected 0",
                     cpi.cpi_ready, cpi.cpi_drop, cpi.cpi_data);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (cpi.cpi_ready !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL rst_mid_busy ready: got 1 expected 0");
        end
        run_op("mul_3x3_after_rst", 4'd0, 32'd3, 32'd3, 32'd9, 1'b1, 33);
    endtask

    task automatic test_back_to_back;
        run_op("b2b_mul", 4'd0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 33);
        run_op("b2b_mulhu", 4'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b1, 33);
        run_op("b2b_divu", 4'd2, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b1, 33);
    endtask

`ifdef CPI_MULDIV_SIGNED_EN
    task automatic test_signed;
        run_op("div_m7_2",     4'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1, 33);
        run_op("rem_m7_2",     4'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1, 33);
        run_op("div_min_m1",   4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
        run_op("rem_min_m1",   4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 33);
        run_op("mulh_m1_m1",   4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 33);
        run_op("mulh_min_2",   4'd4, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 1'b1, 33);
        run_op("div_7_0",      4'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b1, 33);
        run_op("rem_m7_0",     4'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1, 33);
        run_op("div_100_m7",   4'd5, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b1, 33);
    endtask
`endif

    initial begin
        cpi.cpi_valid = 1'b0;
        cpi.cpi_inst  = 32'd0;
        cpi.cpi_r1    = 32'd0;
        cpi.cpi_r2    = 32'd0;
        test_reset();
        test_unsigned();
        test_random();
        test_foreign_op();
        test_bad_subop();
        test_reset_mid_busy();
        test_back_to_back();
`ifdef CPI_MULDIV_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
